elevator_ctrl: RTL and testbench

- Request-issuing end of the availability interface: latches cabin/hall button presses into floor_req and owns the current floor register; both are consumed by the combinational availability unit.
- Uses the returned up/down availability flags to choose travel direction, stop at requested floors, time the door and clear served requests.
- Eight floors (0-7); floor count is fixed, not parameterised.

---
 rtl/elevator_ctrl.sv | 144 ++++++++++++++
 tb/tb_elevator_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Eight-floor elevator controller: latches button requests, owns the floor
// register and sequences MOVE/ARRIVE/DOOR from externally computed availability flags.
module elevator_ctrl #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn,
  input  logic       up_available,
  input  logic       down_available,
  input  logic       up_available_open,
  input  logic       down_available_open,
  output logic [2:0] floor,
  output logic [7:0] floor_req,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic       last_leg
);

  // Availability contract: the four *_available inputs are combinational
  // functions of floor and floor_req as registered here, so a change to either
  // register is reflected in the flags on the following cycle. No handshake.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2,
    DOOR   = 2'd3
  } state_t;

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  state_t     state, state_nx;
  logic [2:0] floor_nx;
  logic       dir_up, dir_up_nx;
  logic [7:0] timer, timer_nx;
  logic       last_leg_nx;
  logic [7:0] clr;
  logic       at_top_guard;

  assign at_top_guard = dir_up ? (floor == 3'd7) : (floor == 3'd0);

  always_comb begin
    state_nx    = state;
    floor_nx    = floor;
    dir_up_nx   = dir_up;
    timer_nx    = timer;
    last_leg_nx = last_leg;
    case (state)
      IDLE: begin
        if (floor_req[floor]) begin
          state_nx = DOOR;
          timer_nx = DOOR_LOAD;
        end else if ((dir_up && up_available_open) ||
                     (!down_available_open && up_available_open)) begin
          state_nx    = MOVE;
          dir_up_nx   = 1'b1;
          timer_nx    = TRAVEL_LOAD;
          last_leg_nx = ~up_available;
        end else if (down_available_open) begin
          state_nx    = MOVE;
          dir_up_nx   = 1'b0;
          timer_nx    = TRAVEL_LOAD;
          last_leg_nx = ~down_available;
        end
      end
      MOVE: begin
        if (timer == 8'd0) begin
          // Travel off either end of the shaft is refused; drop back to IDLE.
          if (at_top_guard) begin
            state_nx    = IDLE;
            last_leg_nx = 1'b0;
          end else begin
            floor_nx = dir_up ? 3'(floor + 3'd1) : 3'(floor - 3'd1);
            state_nx = ARRIVE;
          end
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      ARRIVE: begin
        if (floor_req[floor]) begin
          state_nx    = DOOR;
          timer_nx    = DOOR_LOAD;
          last_leg_nx = 1'b0;
        end else if (dir_up ? up_available_open : down_available_open) begin
          state_nx    = MOVE;
          timer_nx    = TRAVEL_LOAD;
          last_leg_nx = dir_up ? ~up_available : ~down_available;
        end else begin
          state_nx    = IDLE;
          last_leg_nx = 1'b0;
        end
      end
      DOOR: begin
        // A press at this floor holds the door and is absorbed by clr below.
        if (btn[floor]) begin
          timer_nx = DOOR_LOAD;
        end else if (timer == 8'd0) begin
          state_nx = IDLE;
        end else begin
          timer_nx = timer - 8'd1;
        end
      end
      default: begin
        state_nx    = IDLE;
        last_leg_nx = 1'b0;
      end
    endcase
  end

  always_comb begin
    clr = 8'd0;
    if (state == DOOR || state_nx == DOOR) begin
      clr = 8'd1 << floor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      floor     <= 3'd0;
      floor_req <= 8'd0;
      dir_up    <= 1'b1;
      timer     <= 8'd0;
      last_leg  <= 1'b0;
    end else begin
      state     <= state_nx;
      floor     <= floor_nx;
      floor_req <= (floor_req | btn) & ~clr;
      dir_up    <= dir_up_nx;
      timer     <= timer_nx;
      last_leg  <= last_leg_nx;
    end
  end

  assign moving_up   = (state == MOVE) && dir_up;
  assign moving_down = (state == MOVE) && !dir_up;
  assign door_open   = (state == DOOR);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: models the availability unit, tracks
// departure/door events against an expected queue, and checks timing points.
module tb_elevator_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn;
  logic       up_available, down_available;
  logic       up_available_open, down_available_open;
  logic [2:0] floor;
  logic [7:0] floor_req;
  logic       moving_up, moving_down, door_open, last_leg;

  logic       up_a, dn_a, up_o, dn_o;
  logic       ovr_up;
  logic       mon_en;
  logic       prev_mv, prev_door;
  int         checks;
  int         errors;
  logic [7:0] exp_q[$];

  elevator_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .btn                 (btn),
    .up_available        (up_available),
    .down_available      (down_available),
    .up_available_open   (up_available_open),
    .down_available_open (down_available_open),
    .floor               (floor),
    .floor_req           (floor_req),
    .moving_up           (moving_up),
    .moving_down         (moving_down),
    .door_open           (door_open),
    .last_leg            (last_leg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // availability unit model
  always_comb begin
    up_a = 1'b0;
    dn_a = 1'b0;
    up_o = 1'b0;
    dn_o = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (floor_req[i]) begin
        if (i > int'(floor))      up_o = 1'b1;
        if (i >= int'(floor) + 2) up_a = 1'b1;
        if (i < int'(floor))      dn_o = 1'b1;
        if (i <= int'(floor) - 2) dn_a = 1'b1;
      end
    end
  end

  assign up_available        = up_a;
  assign down_available      = dn_a;
  assign up_available_open   = up_o | ovr_up;
  assign down_available_open = dn_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard
  task automatic push_dep(input int dn, input int f, input int ll);
    exp_q.push_back({2'b10, 1'(dn), 3'(f), 1'(ll), 1'b0});
  endtask

  task automatic push_door(input int f);
    exp_q.push_back({2'b01, 1'b0, 3'(f), 1'b0, 1'b0});
  endtask

  task automatic ev_check(input logic [7:0] obs);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
    chk("event", 32'(obs), 32'(e));
  endtask

  // driver: advance one cycle and collect leg-start / door-open events
  task automatic step();
    logic cur_mv;
    @(posedge clk);
    #1;
    cur_mv = moving_up | moving_down;
    if (mon_en) begin
      if (cur_mv && !prev_mv)
        ev_check({2'b10, moving_down, floor, last_leg, 1'b0});
      if (door_open && !prev_door)
        ev_check({2'b01, 1'b0, floor, 1'b0, 1'b0});
    end
    prev_mv   = cur_mv;
    prev_door = door_open;
  endtask

  task automatic press(input logic [7:0] b);
    btn = b;
    step();
    btn = 8'h00;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while (!(floor_req == 8'h00 && !moving_up && !moving_down && !door_open) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(n >= budget), 32'd0);
  endtask

  initial begin
    int n;
    int d;
    rst_n     = 1'b0;
    btn       = 8'h00;
    ovr_up    = 1'b0;
    mon_en    = 1'b1;
    prev_mv   = 1'b0;
    prev_door = 1'b0;
    checks    = 0;
    errors    = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_floor", 32'(floor), 32'd0);
    chk("rst_req", 32'(floor_req), 32'd0);
    chk("rst_mvu", 32'(moving_up), 32'd0);
    chk("rst_mvd", 32'(moving_down), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_ll", 32'(last_leg), 32'd0);
    rst_n = 1'b1;

    // 0 -> 3: latency and door length
    push_dep(0, 0, 0); push_dep(0, 1, 0); push_dep(0, 2, 1); push_door(3);
    press(8'h08);
    chk("req_c1", 32'(floor_req), 32'h08);
    chk("mvu_c1", 32'(moving_up), 32'd0);
    step();
    chk("mvu_c2", 32'(moving_up), 32'd1);
    n = 2;
    while (floor != 3'd3 && n < 100) begin
      step();
      n++;
    end
    chk("floor3_cycle", 32'(n), 32'd16);
    step();
    chk("door_c17", 32'(door_open), 32'd1);
    chk("req_cleared", 32'(floor_req), 32'd0);
    d = 0;
    while (door_open && d < 50) begin
      d++;
      step();
    end
    chk("door_len", 32'(d), 32'd4);
    chk("drain_t1", 32'(exp_q.size()), 32'd0);

    // reset in the middle of travel
    mon_en = 1'b0;
    press(8'h01);
    step();
    chk("mvd_before_rst", 32'(moving_down), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_floor", 32'(floor), 32'd0);
    chk("async_req", 32'(floor_req), 32'd0);
    chk("async_mvd", 32'(moving_down), 32'd0);
    chk("async_ll", 32'(last_leg), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_floor", 32'(floor), 32'd0);
    chk("post_rst_idle", 32'({moving_up, moving_down, door_open, floor_req}), 32'd0);
    mon_en = 1'b1;

    // pass-through: 0 -> 2, then 5 and 7 with 7 pressed en route
    push_dep(0, 0, 0); push_dep(0, 1, 1); push_door(2);
    press(8'h04);
    wait_quiet("t2a_to", 200);
    push_dep(0, 2, 0);
    press(8'h20);
    step();
    push_dep(0, 3, 0); push_dep(0, 4, 0); push_door(5);
    push_dep(0, 5, 0); push_dep(0, 6, 1); push_door(7);
    press(8'h80);
    wait_quiet("t2b_to", 300);
    chk("t2_floor", 32'(floor), 32'd7);
    chk("drain_t2", 32'(exp_q.size()), 32'd0);

    // direction preference: reach 4 heading up, then requests at 6 and 0
    push_dep(1, 7, 0); push_dep(1, 6, 0); push_dep(1, 5, 0); push_dep(1, 4, 1); push_door(3);
    press(8'h08);
    wait_quiet("t3a_to", 300);
    push_dep(0, 3, 1); push_door(4);
    press(8'h10);
    wait_quiet("t3b_to", 200);
    push_dep(0, 4, 0); push_dep(0, 5, 1); push_door(6);
    push_dep(1, 6, 0); push_dep(1, 5, 0); push_dep(1, 4, 0);
    push_dep(1, 3, 0); push_dep(1, 2, 0); push_dep(1, 1, 1); push_door(0);
    press(8'h41);
    wait_quiet("t3c_to", 400);
    chk("t3_floor", 32'(floor), 32'd0);
    chk("drain_t3", 32'(exp_q.size()), 32'd0);

    // same-floor press holds the door; simultaneous press elsewhere latches
    push_dep(0, 0, 0); push_dep(0, 1, 0); push_dep(0, 2, 0); push_dep(0, 3, 1); push_door(4);
    press(8'h10);
    n = 0;
    while (!door_open && n < 200) begin
      step();
      n++;
    end
    chk("t4_door_to", 32'(n >= 200), 32'd0);
    step();
    step();
    push_dep(1, 4, 0); push_dep(1, 3, 0); push_dep(1, 2, 1); push_door(1);
    press(8'h12);
    chk("absorb_req", 32'(floor_req), 32'h02);
    d = 0;
    while (door_open && d < 50) begin
      d++;
      step();
    end
    chk("door_restart_len", 32'(d), 32'd4);
    wait_quiet("t4_to", 200);
    chk("t4_floor", 32'(floor), 32'd1);
    chk("drain_t4", 32'(exp_q.size()), 32'd0);

    // top boundary
    push_dep(0, 1, 0); push_dep(0, 2, 0); push_dep(0, 3, 0);
    push_dep(0, 4, 0); push_dep(0, 5, 0); push_dep(0, 6, 1); push_door(7);
    press(8'h80);
    wait_quiet("t5a_to", 300);
    push_door(7);
    press(8'h80);
    step();
    chk("t5_no_up", 32'(moving_up), 32'd0);
    wait_quiet("t5b_to", 100);
    chk("t5_floor7", 32'(floor), 32'd7);

    // spurious upward request at 7 trips the shaft guard
    mon_en = 1'b0;
    ovr_up = 1'b1;
    step();
    ovr_up = 1'b0;
    chk("guard_mvu", 32'(moving_up), 32'd1);
    chk("guard_ll", 32'(last_leg), 32'd1);
    repeat (4) step();
    chk("guard_stop", 32'({moving_up, moving_down}), 32'd0);
    chk("guard_floor", 32'(floor), 32'd7);
    chk("guard_ll_clr", 32'(last_leg), 32'd0);
    step();
    mon_en = 1'b1;

    push_dep(1, 7, 0); push_dep(1, 6, 0); push_dep(1, 5, 0); push_dep(1, 4, 0);
    push_dep(1, 3, 0); push_dep(1, 2, 0); push_dep(1, 1, 1); push_door(0);
    press(8'h01);
    wait_quiet("t5c_to", 400);
    chk("t5_floor0", 32'(floor), 32'd0);
    chk("drain_final", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
